// File: rtl/pc_redirect_ctrl_pkg.sv
// rtl/pc_redirect_ctrl_pkg.sv - shared pipeline-control types and constants
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MC_WAIT = 2'd1,
        FLUSH   = 2'd2
    } state_t;

    localparam logic [31:0] RESET_VECTOR = 32'h00400000;
    localparam logic [4:0]  REG_ZERO     = 5'd0;

    localparam int FLUSH_CNT_W = 3;
    typedef logic [FLUSH_CNT_W-1:0] flush_cnt_t;

endpackage

// File: rtl/pc_redirect_ctrl_if.sv
// rtl/pc_redirect_ctrl_if.sv - ID/EX status inputs and PC/squash control outputs
interface pc_redirect_ctrl_if #(
    parameter int XLEN = 32
);
    logic            id_valid;
    logic [4:0]      id_rs1;
    logic [4:0]      id_rs2;
    logic            id_use_rs1;
    logic            id_use_rs2;
    logic            ex_valid;
    logic            ex_is_load;
    logic [4:0]      ex_rd;
    logic            ex_branch;
    logic            ex_taken;
    logic [XLEN-1:0] ex_target;
    logic            ex_mc_start;
    logic            ex_mc_done;
    logic            stall;
    logic            succ;
    logic [XLEN-1:0] new_addr;
    logic            flush_front;
    logic            bubble_ex;
    logic            misalign;

    modport master (
        output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        output ex_valid, ex_is_load, ex_rd, ex_branch, ex_taken, ex_target,
        output ex_mc_start, ex_mc_done,
        input  stall, succ, new_addr, flush_front, bubble_ex, misalign
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        input  ex_valid, ex_is_load, ex_rd, ex_branch, ex_taken, ex_target,
        input  ex_mc_start, ex_mc_done,
        output stall, succ, new_addr, flush_front, bubble_ex, misalign
    );
endinterface

// File: rtl/pc_redirect_ctrl_load_use_detect.sv
// rtl/pc_redirect_ctrl_load_use_detect.sv - combinational load-use hazard compare
module load_use_detect
    import pipe_ctrl_pkg::*;
(
    input  logic       id_valid,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_use_rs1,
    input  logic       id_use_rs2,
    input  logic       ex_valid,
    input  logic       ex_is_load,
    input  logic [4:0] ex_rd,
    output logic       hazard
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit = id_use_rs1 && (id_rs1 == ex_rd);
    assign rs2_hit = id_use_rs2 && (id_rs2 == ex_rd);

    // x0 is never really written, so a load targeting it cannot create a dependency
    assign hazard = id_valid && ex_valid && ex_is_load &&
                    (ex_rd != REG_ZERO) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pc_redirect_ctrl.sv
// rtl/pc_redirect_ctrl.sv - PC stall/redirect and front-end squash control; option macro MISALIGN_TRAP_EN
module pc_redirect_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter int              FLUSH_DEPTH = 2,
    parameter logic [XLEN-1:0] TRAP_VECTOR = 32'h00400100
) (
    input  logic              clock,
    input  logic              reset_n,
    pc_redirect_ctrl_if.slave bus
);

`ifdef MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    state_t          state_q, state_n;
    flush_cnt_t      cnt_q, cnt_n;
    logic            succ_q, succ_n;
    logic            mis_q, mis_n;
    logic [XLEN-1:0] addr_q, addr_n;

    logic hazard;
    logic redirect;
    logic trap;

    load_use_detect u_load_use_detect (
        .id_valid   (bus.id_valid),
        .id_rs1     (bus.id_rs1),
        .id_rs2     (bus.id_rs2),
        .id_use_rs1 (bus.id_use_rs1),
        .id_use_rs2 (bus.id_use_rs2),
        .ex_valid   (bus.ex_valid),
        .ex_is_load (bus.ex_is_load),
        .ex_rd      (bus.ex_rd),
        .hazard     (hazard)
    );

    assign redirect = bus.ex_valid && bus.ex_branch && bus.ex_taken;
    assign trap     = TRAP_EN && (bus.ex_target[1:0] != 2'b00);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= RUN;
            cnt_q   <= '0;
            succ_q  <= 1'b0;
            mis_q   <= 1'b0;
            addr_q  <= '0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            succ_q  <= succ_n;
            mis_q   <= mis_n;
            addr_q  <= addr_n;
        end
    end

    always_comb begin
        state_n         = state_q;
        cnt_n           = cnt_q;
        succ_n          = 1'b0;
        mis_n           = 1'b0;
        addr_n          = addr_q;
        bus.stall       = 1'b0;
        bus.bubble_ex   = 1'b0;
        bus.flush_front = 1'b0;
        unique case (state_q)
            RUN: begin
                // redirect outranks a multi-cycle start, which outranks a load-use stall
                if (redirect) begin
                    succ_n  = 1'b1;
                    mis_n   = trap;
                    addr_n  = trap ? TRAP_VECTOR : bus.ex_target;
                    cnt_n   = flush_cnt_t'(FLUSH_DEPTH);
                    state_n = FLUSH;
                end else if (bus.ex_mc_start) begin
                    state_n = MC_WAIT;
                end else if (hazard) begin
                    bus.stall     = 1'b1;
                    bus.bubble_ex = 1'b1;
                end
            end
            MC_WAIT: begin
                if (bus.ex_mc_done) begin
                    state_n = RUN;
                end else begin
                    bus.stall = 1'b1;
                end
            end
            FLUSH: begin
                // the squashed instructions' hazard and mc_start inputs are ignored here
                if (cnt_q != '0) begin
                    bus.flush_front = 1'b1;
                    bus.bubble_ex   = 1'b1;
                    cnt_n           = cnt_q - 1'b1;
                end
                if (cnt_q <= flush_cnt_t'(1)) begin
                    state_n = RUN;
                end
            end
            default: begin
                state_n = RUN;
                cnt_n   = '0;
            end
        endcase
    end

    assign bus.succ     = succ_q;
    assign bus.misalign = mis_q;
    assign bus.new_addr = addr_q;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// tb/tb_pc_redirect_ctrl.sv - directed scoreboard bench for pc_redirect_ctrl
module tb_pc_redirect_ctrl;

    logic clock = 1'b0;
    logic reset_n = 1'b0;

    always #5 clock = ~clock;

    pc_redirect_ctrl_if #(.XLEN(32)) bus ();

    pc_redirect_ctrl #(
        .XLEN        (32),
        .FLUSH_DEPTH (2),
        .TRAP_VECTOR (32'h00400100)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

`ifdef MISALIGN_TRAP_EN
    localparam logic [31:0] MIS_ADDR = 32'h00400100;
    localparam logic        MIS_BIT  = 1'b1;
`else
    localparam logic [31:0] MIS_ADDR = 32'h00400042;
    localparam logic        MIS_BIT  = 1'b0;
`endif

    typedef struct {
        string       tag;
        logic        stall;
        logic        succ;
        logic        ff;
        logic        bub;
        logic        mis;
        logic [31:0] addr;
    } exp_t;

    exp_t exp_q[$];
    int   n_asrt = 0;
    int   n_fail = 0;

    task automatic push_exp(input string tag, input logic st, input logic su, input logic ff,
                            input logic bb, input logic ms, input logic [31:0] a);
        exp_t e;
        e.tag = tag; e.stall = st; e.succ = su; e.ff = ff; e.bub = bb; e.mis = ms; e.addr = a;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string tag, input string fld, input logic [31:0] obs, input logic [31:0] expv);
        n_asrt++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s.%s observed=%h expected=%h", tag, fld, obs, expv);
        end
    endtask

    // compare one cycle's outputs against the oldest expectation, then advance a clock
    task automatic tick();
        exp_t e;
        @(negedge clock);
        n_asrt++;
        assert (exp_q.size() != 0) else begin
            n_fail++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
        end
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk(e.tag, "stall",       {31'd0, bus.stall},       {31'd0, e.stall});
            chk(e.tag, "succ",        {31'd0, bus.succ},        {31'd0, e.succ});
            chk(e.tag, "flush_front", {31'd0, bus.flush_front}, {31'd0, e.ff});
            chk(e.tag, "bubble_ex",   {31'd0, bus.bubble_ex},   {31'd0, e.bub});
            chk(e.tag, "misalign",    {31'd0, bus.misalign},    {31'd0, e.mis});
            chk(e.tag, "new_addr",    bus.new_addr,             e.addr);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic clear_in();
        bus.id_valid = 0; bus.id_rs1 = 0; bus.id_rs2 = 0; bus.id_use_rs1 = 0; bus.id_use_rs2 = 0;
        bus.ex_valid = 0; bus.ex_is_load = 0; bus.ex_rd = 0; bus.ex_branch = 0; bus.ex_taken = 0;
        bus.ex_target = 0; bus.ex_mc_start = 0; bus.ex_mc_done = 0;
    endtask

    task automatic set_load_use(input logic [4:0] rd);
        bus.id_valid = 1; bus.ex_valid = 1; bus.ex_is_load = 1; bus.ex_rd = rd;
        bus.id_rs2 = 5'd5; bus.id_use_rs2 = 1;
    endtask

    task automatic set_branch(input logic [31:0] tgt);
        bus.ex_valid = 1; bus.ex_branch = 1; bus.ex_taken = 1; bus.ex_target = tgt;
    endtask

    initial begin
        clear_in();
        reset_n = 0;
        @(posedge clock); #1;
        push_exp("reset", 0, 0, 0, 0, 0, 32'h0);
        tick();
        reset_n = 1;

        // taken branch: succ and two flush cycles, then back to RUN
        set_branch(32'h00400040);
        push_exp("br_t", 0, 0, 0, 0, 0, 32'h0);
        tick();
        clear_in();
        push_exp("br_t1", 0, 1, 1, 1, 0, 32'h00400040);
        push_exp("br_t2", 0, 0, 1, 1, 0, 32'h00400040);
        push_exp("br_run", 0, 0, 0, 0, 0, 32'h00400040);
        repeat (3) tick();

        // not-taken branch does not redirect
        bus.ex_valid = 1; bus.ex_branch = 1; bus.ex_taken = 0; bus.ex_target = 32'h00400200;
        push_exp("br_nt", 0, 0, 0, 0, 0, 32'h00400040);
        tick();
        clear_in();
        push_exp("br_nt1", 0, 0, 0, 0, 0, 32'h00400040);
        tick();

        // load-use on rs2, then rd=x0, then rs1 path, unused rs1, and non-load
        set_load_use(5'd5);
        push_exp("lu_rs2", 1, 0, 0, 1, 0, 32'h00400040);
        tick();
        bus.ex_rd = 5'd0;
        push_exp("lu_x0", 0, 0, 0, 0, 0, 32'h00400040);
        tick();
        bus.id_use_rs2 = 0; bus.id_use_rs1 = 1; bus.id_rs1 = 5'd7; bus.ex_rd = 5'd7;
        push_exp("lu_rs1", 1, 0, 0, 1, 0, 32'h00400040);
        tick();
        bus.id_use_rs1 = 0;
        push_exp("lu_nouse", 0, 0, 0, 0, 0, 32'h00400040);
        tick();
        bus.id_use_rs1 = 1; bus.ex_is_load = 0;
        push_exp("lu_noload", 0, 0, 0, 0, 0, 32'h00400040);
        tick();
        clear_in();

        // multi-cycle op: start at t, done at t+5; a hazard in MC_WAIT gives no bubble
        bus.ex_valid = 1; bus.ex_mc_start = 1;
        push_exp("mc_t", 0, 0, 0, 0, 0, 32'h00400040);
        tick();
        clear_in();
        push_exp("mc_w1", 1, 0, 0, 0, 0, 32'h00400040);
        tick();
        set_load_use(5'd5);
        push_exp("mc_w2", 1, 0, 0, 0, 0, 32'h00400040);
        tick();
        clear_in();
        push_exp("mc_w3", 1, 0, 0, 0, 0, 32'h00400040);
        push_exp("mc_w4", 1, 0, 0, 0, 0, 32'h00400040);
        repeat (2) tick();
        bus.ex_mc_done = 1;
        push_exp("mc_done", 0, 0, 0, 0, 0, 32'h00400040);
        tick();
        clear_in();
        push_exp("mc_run", 0, 0, 0, 0, 0, 32'h00400040);
        tick();

        // load-use + branch + mc_start together: redirect wins, no stall
        set_load_use(5'd5);
        set_branch(32'h00400080);
        bus.ex_mc_start = 1;
        push_exp("prio_t", 0, 0, 0, 0, 0, 32'h00400040);
        tick();
        bus.ex_branch = 0; bus.ex_taken = 0;
        push_exp("prio_f1", 0, 1, 1, 1, 0, 32'h00400080);
        push_exp("prio_f2", 0, 0, 1, 1, 0, 32'h00400080);
        repeat (2) tick();
        clear_in();
        push_exp("prio_run", 0, 0, 0, 0, 0, 32'h00400080);
        tick();

        // reset during the second FLUSH cycle
        set_branch(32'h004000c0);
        push_exp("rstf_t", 0, 0, 0, 0, 0, 32'h00400080);
        tick();
        clear_in();
        push_exp("rstf_f1", 0, 1, 1, 1, 0, 32'h004000c0);
        tick();
        reset_n = 0;
        push_exp("rstf_f2", 0, 0, 1, 1, 0, 32'h004000c0);
        tick();
        reset_n = 1;
        push_exp("rstf_after", 0, 0, 0, 0, 0, 32'h0);
        push_exp("rstf_run", 0, 0, 0, 0, 0, 32'h0);
        repeat (2) tick();

        // reset during MC_WAIT
        bus.ex_valid = 1; bus.ex_mc_start = 1;
        push_exp("rstm_t", 0, 0, 0, 0, 0, 32'h0);
        tick();
        clear_in();
        reset_n = 0;
        push_exp("rstm_w", 1, 0, 0, 0, 0, 32'h0);
        tick();
        reset_n = 1;
        push_exp("rstm_after", 0, 0, 0, 0, 0, 32'h0);
        tick();

        // misaligned target: trapped only when the option is built in
        set_branch(32'h00400042);
        push_exp("mis_t", 0, 0, 0, 0, 0, 32'h0);
        tick();
        clear_in();
        push_exp("mis_f1", 0, 1, 1, 1, MIS_BIT, MIS_ADDR);
        push_exp("mis_f2", 0, 0, 1, 1, 0, MIS_ADDR);
        push_exp("mis_run", 0, 0, 0, 0, 0, MIS_ADDR);
        repeat (3) tick();

        n_asrt++;
        assert (exp_q.size() == 0) else begin
            n_fail++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_redirect_ctrl.md
# pc_redirect_ctrl

Control block that drives the program counter's `stall`, `succ` and `new_addr` inputs. It sits beside the ID/EX pipeline registers and does three jobs:
- turns EX-stage branch resolution into a registered redirect;
- detects load-use and multi-cycle-op hazards and holds the PC while they last;
- issues squash signals to the front pipeline stages after every redirect.

## Interface
Parameters:
- XLEN, 32, address/data width
- FLUSH_DEPTH, 2, cycles of front-end squash after a redirect (1..7)
- TRAP_VECTOR, 32'h00400100, redirect target for misaligned branch targets (used only with MISALIGN_TRAP_EN)

Ports:
- clock  in  1  single clock, rising edge
- reset_n  in  1  synchronous, active-low reset
- id_valid  in  1  ID stage holds a live instruction
- id_rs1, id_rs2  in  5  ID source registers
- id_use_rs1, id_use_rs2  in  1  source actually read
- ex_valid  in  1  EX stage holds a live instruction
- ex_is_load  in  1  EX instruction is a load
- ex_rd  in  5  EX destination register
- ex_branch  in  1  EX instruction is a branch/jump
- ex_taken  in  1  branch resolved taken (qualified by ex_branch)
- ex_target  in  XLEN  resolved target
- ex_mc_start  in  1  multi-cycle op (mul/div) entered EX this cycle
- ex_mc_done  in  1  multi-cycle op result ready
- stall  out  1  to PC: hold current address
- succ  out  1  to PC: load new_addr
- new_addr  out  XLEN  redirect target
- flush_front  out  1  squash IF/ID register
- bubble_ex  out  1  insert NOP into ID/EX register
- misalign  out  1  one-cycle pulse on trapped target (0 when macro absent)

## Operation
- Load-use hazard: id_valid & ex_valid & ex_is_load & ex_rd≠0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
- Taken redirect: ex_valid & ex_branch & ex_taken.
- State machine, states RUN, MC_WAIT, FLUSH:
  - RUN:
    - A taken redirect registers succ=1 and new_addr=ex_target for the next cycle, loads the flush counter with FLUSH_DEPTH, and moves to FLUSH.
    - Otherwise, ex_mc_start moves to MC_WAIT.
    - Otherwise, a load-use hazard gives stall=1 and bubble_ex=1 combinationally for one cycle; the state stays RUN.
  - MC_WAIT: stall=1 and bubble_ex=0 every cycle until ex_mc_done. The cycle ex_mc_done is seen, stall=0 and the state returns to RUN. A redirect cannot occur while in MC_WAIT.
  - FLUSH: flush_front=1 and bubble_ex=1 while the counter is >0. The counter decrements every cycle; at 1 the state returns to RUN. Hazard and ex_mc_start inputs are ignored, because the instructions they describe are squashed.
- Priority within one cycle: redirect > multi-cycle start > load-use. A redirect coinciding with a load-use hazard produces no stall.
- Only the outputs of the state in force apply: succ and stall are never both 1.
- succ is a single-cycle pulse. new_addr holds its value until the next redirect.
- Arithmetic: no PC arithmetic is done here. The flush counter is 3 bits and must not wrap below 0.

## Timing
- Reset (reset_n=0 at a clock edge) forces:
  - state=RUN, flush counter=0;
  - succ=0, stall=0, flush_front=0, bubble_ex=0, misalign=0;
  - new_addr=0.
- Reset mid-FLUSH or mid-MC_WAIT abandons the operation immediately.
- Redirect latency: branch resolved in EX at cycle t gives succ=1 in cycle t+1. The PC loads new_addr at the end of t+1.
- flush_front is asserted for cycles t+1 .. t+FLUSH_DEPTH.
- stall is combinational from the ID/EX inputs in RUN and from registered state in MC_WAIT.
- A load-use stall lasts exactly one cycle per hazard.

## Configuration
- MISALIGN_TRAP_EN defined:
  - A taken redirect with ex_target[1:0]≠0 sets new_addr=TRAP_VECTOR and pulses misalign in the same cycle as succ.
  - FLUSH proceeds normally.
- Macro undefined: ex_target is passed through unchecked and misalign is tied 0.

## Structure
- Shared package `pipe_ctrl_pkg`:
  - state enum (RUN, MC_WAIT, FLUSH);
  - RESET_VECTOR 32'h00400000;
  - REG_ZERO 5'd0;
  - FLUSH counter width.
- One sub-module, `load_use_detect`: purely combinational hazard compare, reused by the forwarding unit.

## Test plan
- Branch at t, ex_target=32'h00400040 → succ=1 and new_addr=32'h00400040 at t+1; flush_front=1 at t+1,t+2 (FLUSH_DEPTH=2); then RUN.
- ex_is_load, ex_rd=5, id_rs2=5, id_use_rs2=1 → stall=1 and bubble_ex=1 for one cycle; repeat with ex_rd=0 → stall=0.
- ex_mc_start at t, ex_mc_done at t+5 → stall=1 at t+1..t+4, stall=0 at t+5.
- Load-use hazard and taken branch in the same cycle → stall=0, succ=1 the next cycle.
- reset_n=0 during the second FLUSH cycle → all outputs 0 the next cycle, state RUN, new_addr=0.
- With MISALIGN_TRAP_EN: ex_target=32'h00400042 → new_addr=TRAP_VECTOR and misalign=1 for one cycle, coincident with succ.
